// File: rtl/simple_bist_pkg.sv
// rtl/simple_bist_pkg.sv - shared types, constants and LFSR step for simple_bist
package simple_bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_t;

  localparam logic [7:0]  LFSR_SEED = 8'h01;
  localparam logic [7:0]  LFSR_TAPS = 8'hB8;
  localparam logic [15:0] MISR_POLY = 16'h1021;
  localparam int          SIG_W     = 16;

  // Fibonacci shift-left step; feedback is the XOR of the tapped bits
  function automatic logic [7:0] lfsr_next(input logic [7:0] l);
    return {l[6:0], ^(l & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/simple_bist_misr.sv
// rtl/simple_bist_misr.sv - 16-bit single-input MISR with clear and enable
module simple_bist_misr
  import simple_bist_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic             din,
  output logic [SIG_W-1:0] sig,
  output logic [SIG_W-1:0] sig_next
);

  // sig_next is exposed so the golden compare can see the final value on the same edge
  assign sig_next = {sig[SIG_W-2:0], 1'b0}
                  ^ (sig[SIG_W-1] ? MISR_POLY : '0)
                  ^ {{(SIG_W-1){1'b0}}, din};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig <= '0;
    end else if (clr) begin
      sig <= '0;
    end else if (en) begin
      sig <= sig_next;
    end
  end

endmodule

// File: rtl/simple_bist.sv
// rtl/simple_bist.sv - LFSR pattern driver and MISR compactor; SIMPLE_BIST_GOLDEN_EN adds the pass compare
module simple_bist
  import simple_bist_pkg::*;
#(
  parameter int          NUM_PATTERNS = 64,
  parameter int          SETTLE_CYC   = 2,
  parameter logic [15:0] GOLDEN_SIG   = 16'h0000
) (
  input  logic             tau2015_clk,
  input  logic             tau2015_rst_n,
  input  logic             start,
  input  logic             dut_out,
  output logic             inp1,
  output logic             inp2,
  output logic             busy,
  output logic             done,
  output logic [SIG_W-1:0] signature,
  output logic             pass
);

  localparam int CNT_W = $clog2(NUM_PATTERNS + 1);
  localparam int SET_W = $clog2(SETTLE_CYC + 1);

  state_t           state;
  logic [7:0]       lfsr;
  logic [7:0]       lfsr_nxt;
  logic [CNT_W-1:0] pat_cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [SET_W-1:0] settle_cnt;
  logic             start_run;
  logic             sample_en;
  logic             more_pats;
  logic [SIG_W-1:0] sig_next;

  assign lfsr_nxt  = lfsr_next(lfsr);
  assign cnt_inc   = pat_cnt + CNT_W'(1);
  assign more_pats = cnt_inc < CNT_W'(NUM_PATTERNS);
  assign start_run = (state == ST_IDLE) && start;
  assign sample_en = (state == ST_SAMPLE);

  always_ff @(posedge tau2015_clk or negedge tau2015_rst_n) begin
    if (!tau2015_rst_n) begin
      state      <= ST_IDLE;
      lfsr       <= LFSR_SEED;
      inp1       <= 1'b0;
      inp2       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pat_cnt    <= '0;
      settle_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state   <= ST_DRIVE;
            lfsr    <= LFSR_SEED;
            inp1    <= LFSR_SEED[0];
            inp2    <= LFSR_SEED[1];
            pat_cnt <= '0;
            busy    <= 1'b1;
          end
        end
        ST_DRIVE: begin
          state      <= ST_SETTLE;
          settle_cnt <= '0;
        end
        ST_SETTLE: begin
          if (settle_cnt == SET_W'(SETTLE_CYC - 1)) begin
            state <= ST_SAMPLE;
          end else begin
            settle_cnt <= settle_cnt + SET_W'(1);
          end
        end
        ST_SAMPLE: begin
          // the pattern changes only after its response has been captured
          pat_cnt <= cnt_inc;
          lfsr    <= lfsr_nxt;
          inp1    <= lfsr_nxt[0];
          inp2    <= lfsr_nxt[1];
          if (more_pats) begin
            state <= ST_DRIVE;
          end else begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          done  <= 1'b0;
          inp1  <= 1'b0;
          inp2  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  simple_bist_misr u_misr (
    .clk      (tau2015_clk),
    .rst_n    (tau2015_rst_n),
    .clr      (start_run),
    .en       (sample_en),
    .din      (dut_out),
    .sig      (signature),
    .sig_next (sig_next)
  );

`ifdef SIMPLE_BIST_GOLDEN_EN
  always_ff @(posedge tau2015_clk or negedge tau2015_rst_n) begin
    if (!tau2015_rst_n) begin
      pass <= 1'b0;
    end else if (start_run) begin
      pass <= 1'b0;
    end else if (sample_en && !more_pats) begin
      pass <= (sig_next == GOLDEN_SIG);
    end
  end
`else
  assign pass = 1'b0 & (^GOLDEN_SIG);
`endif

endmodule

// File: tb/tb_simple_bist.sv
// tb/tb_simple_bist.sv - self-checking bench for simple_bist against a behavioural model
module tb_simple_bist;

  localparam int S = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  start_v;
  logic [3:0]  dout_v;
  logic [3:0]  inp1_v, inp2_v, busy_v, done_v, pass_v;
  logic [15:0] sig_v [4];
  logic [3:0]  tbl [4];
  int          np [4];
  logic [15:0] gold [4];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  // the netlist under test is modelled as a 2-input truth table
  assign dout_v[0] = tbl[0][{inp2_v[0], inp1_v[0]}];
  assign dout_v[1] = tbl[1][{inp2_v[1], inp1_v[1]}];
  assign dout_v[2] = tbl[2][{inp2_v[2], inp1_v[2]}];
  assign dout_v[3] = tbl[3][{inp2_v[3], inp1_v[3]}];

  simple_bist #(.NUM_PATTERNS(5), .SETTLE_CYC(S), .GOLDEN_SIG(16'h0000)) u_n5 (
    .tau2015_clk(clk), .tau2015_rst_n(rst_n), .start(start_v[0]), .dut_out(dout_v[0]),
    .inp1(inp1_v[0]), .inp2(inp2_v[0]), .busy(busy_v[0]), .done(done_v[0]),
    .signature(sig_v[0]), .pass(pass_v[0]));

  simple_bist #(.NUM_PATTERNS(2), .SETTLE_CYC(S), .GOLDEN_SIG(16'h0003)) u_n2a (
    .tau2015_clk(clk), .tau2015_rst_n(rst_n), .start(start_v[1]), .dut_out(dout_v[1]),
    .inp1(inp1_v[1]), .inp2(inp2_v[1]), .busy(busy_v[1]), .done(done_v[1]),
    .signature(sig_v[1]), .pass(pass_v[1]));

  simple_bist #(.NUM_PATTERNS(2), .SETTLE_CYC(S), .GOLDEN_SIG(16'h0002)) u_n2b (
    .tau2015_clk(clk), .tau2015_rst_n(rst_n), .start(start_v[2]), .dut_out(dout_v[2]),
    .inp1(inp1_v[2]), .inp2(inp2_v[2]), .busy(busy_v[2]), .done(done_v[2]),
    .signature(sig_v[2]), .pass(pass_v[2]));

  simple_bist #(.NUM_PATTERNS(1), .SETTLE_CYC(S), .GOLDEN_SIG(16'h0000)) u_n1 (
    .tau2015_clk(clk), .tau2015_rst_n(rst_n), .start(start_v[3]), .dut_out(dout_v[3]),
    .inp1(inp1_v[3]), .inp2(inp2_v[3]), .busy(busy_v[3]), .done(done_v[3]),
    .signature(sig_v[3]), .pass(pass_v[3]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // LFSR state for pattern p, stepped with plain integer arithmetic
  function automatic int lfsr_at(input int p);
    int lf = 1;
    for (int i = 0; i < p; i++)
      lf = ((lf << 1) & 255) | (((lf >> 7) ^ (lf >> 5) ^ (lf >> 4) ^ (lf >> 3)) & 1);
    return lf;
  endfunction

  // expected signature: CRC-style shift of each response bit in pattern order
  function automatic logic [15:0] model_sig(input int n, input logic [3:0] t);
    int s = 0;
    for (int p = 0; p < n; p++) begin
      int b = (int'(t) >> (lfsr_at(p) & 3)) & 1;
      int fb = (s >> 15) & 1;
      s = ((s << 1) & 16'hFFFF) ^ (fb != 0 ? 16'h1021 : 0) ^ b;
    end
    return 16'(s);
  endfunction

  function automatic logic exp_pass(input int sel, input logic [15:0] sig);
`ifdef SIMPLE_BIST_GOLDEN_EN
    return sig == gold[sel];
`else
    return 1'b0 & (sig == gold[sel]);
`endif
  endfunction

  task automatic check_idle(input int sel);
    check("idle_busy", 32'(busy_v[sel]), 0);
    check("idle_done", 32'(done_v[sel]), 0);
    check("idle_inp", 32'({inp2_v[sel], inp1_v[sel]}), 0);
    check("idle_sig", 32'(sig_v[sel]), 0);
    check("idle_pass", 32'(pass_v[sel]), 0);
  endtask

  // one start pulse, then a cycle-by-cycle check through DONE and one cycle after
  task automatic run(input int sel, input bit mid_start);
    int per = S + 2;
    int total = np[sel] * per;
    logic [15:0] es = model_sig(np[sel], tbl[sel]);
    logic ep = exp_pass(sel, es);
    @(negedge clk); start_v[sel] = 1'b1;
    @(negedge clk); start_v[sel] = 1'b0;
    for (int c = 1; c <= total + 2; c++) begin
      int p = (c - 1) / per;
      int off = (c - 1) % per;
      if (c > 1) @(negedge clk);
      start_v[sel] = mid_start && (c == per + 2);
      check("busy", 32'(busy_v[sel]), 32'(c <= total));
      check("done", 32'(done_v[sel]), 32'(c == total + 1));
      if (c <= total && off < S + 1)
        check("pattern", 32'({inp2_v[sel], inp1_v[sel]}), lfsr_at(p) & 3);
      if (c == total + 1) begin
        check("signature", 32'(sig_v[sel]), 32'(es));
        check("pass", 32'(pass_v[sel]), 32'(ep));
      end
      if (c == total + 2) begin
        check("inp_after", 32'({inp2_v[sel], inp1_v[sel]}), 0);
        check("sig_held", 32'(sig_v[sel]), 32'(es));
        check("pass_held", 32'(pass_v[sel]), 32'(ep));
      end
    end
    start_v[sel] = 1'b0;
  endtask

  initial begin
    int dq [$];
    int per;
    np = '{5, 2, 2, 1};
    gold = '{16'h0000, 16'h0003, 16'h0002, 16'h0000};
    tbl = '{4'h0, 4'hF, 4'hF, 4'h0};
    start_v = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 4; i++) check_idle(i);

    // all-zero response, then a mid-run start that must be ignored
    run(0, 1'b0);
    run(0, 1'b1);

    // constant-one response over two patterns, against two golden values
    run(1, 1'b0);
    run(2, 1'b0);

    for (int r = 0; r < 4; r++) begin
      tbl[0] = 4'($urandom);
      run(0, r[0]);
    end
    for (int r = 0; r < 3; r++) begin
      tbl[1] = 4'($urandom);
      tbl[2] = tbl[1];
      run(1, 1'b0);
      run(2, 1'b0);
    end

    // reset pulse during the third pattern, then a clean rerun
    tbl[0] = 4'($urandom) | 4'h1;
    @(negedge clk); start_v[0] = 1'b1;
    @(negedge clk); start_v[0] = 1'b0;
    repeat (2 * (S + 2) + 1) @(negedge clk);
    check("pre_reset_busy", 32'(busy_v[0]), 1);
    #2 rst_n = 1'b0;
    #1;
    check_idle(0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_idle(0);
    run(0, 1'b0);

    // start held high with one pattern: back-to-back runs
    tbl[3] = 4'hF;
    per = S + 4;
    @(negedge clk); start_v[3] = 1'b1;
    for (int c = 1; c <= 5 * per; c++) begin
      @(negedge clk);
      if (done_v[3]) begin
        dq.push_back(c);
        check("held_sig", 32'(sig_v[3]), 32'(model_sig(1, tbl[3])));
      end
    end
    start_v[3] = 1'b0;
    check("held_done_count", dq.size() >= 3 ? 1 : 0, 1);
    if (dq.size() > 0) check("held_first_done", dq[0], S + 3);
    for (int i = 1; i < dq.size(); i++) check("held_period", dq[i] - dq[i-1], per);

    repeat (S + 6) @(negedge clk);
    check("final_idle_busy", 32'(busy_v[3]), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/simple_bist.md
# simple_bist

Self-test driver and response compactor for the small `inp1`/`inp2` → `out` example netlist used in timing regression. On `start`, it does the following for each of `NUM_PATTERNS` patterns:
- drives LFSR-generated patterns onto the netlist's two data inputs,
- waits a programmable settle time,
- samples the netlist output into a 16-bit MISR signature.

It is the stimulus and response end of that netlist's primary I/O and runs on the same clock as the netlist's flop.

## Interface
- `NUM_PATTERNS`, 64: patterns per run; legal range ≥1.
- `SETTLE_CYC`, 2: cycles between driving a pattern and sampling; legal range ≥1.
- `GOLDEN_SIG`, 16'h0000: expected final signature; used only with `SIMPLE_BIST_GOLDEN_EN`.
- `tau2015_clk`  in  1  single clock; all state changes on rising edge.
- `tau2015_rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  run request; sampled only in IDLE.
- `dut_out`  in  1  netlist output under test.
- `inp1`  out  1  pattern bit 0 to netlist.
- `inp2`  out  1  pattern bit 1 to netlist.
- `busy`  out  1  run in progress.
- `done`  out  1  one-cycle pulse when the run completes.
- `signature`  out  16  MISR value; held after the run.
- `pass`  out  1  signature equals `GOLDEN_SIG`; valid while `done` is high and held until the next start.

## Operation
- FSM states and transitions:
  - IDLE → DRIVE when `start`=1.
  - DRIVE → SETTLE, always.
  - SETTLE → SAMPLE after `SETTLE_CYC` cycles.
  - SAMPLE → DRIVE if the pattern count is below `NUM_PATTERNS`; otherwise SAMPLE → DONE.
  - DONE → IDLE, always.
- LFSR:
  - 8-bit Fibonacci, shift left; feedback = l[7]^l[5]^l[4]^l[3]; seed 8'h01.
  - Sequence from seed: 01, 02, 04, 08, 11, …
- Pattern mapping: `inp1`=lfsr[0], `inp2`=lfsr[1].
- On the IDLE→DRIVE edge:
  - LFSR ← seed;
  - `inp1`/`inp2` ← seed bits;
  - signature ← 0; pattern count ← 0; `pass` ← 0.
- On each SAMPLE edge:
  - signature ← {sig[14:0],0} ^ (sig[15] ? 16'h1021 : 0) ^ {15'b0,`dut_out`};
  - pattern count +1;
  - LFSR ← next(LFSR);
  - `inp1`/`inp2` ← bits of next(LFSR).
- On the DONE→IDLE edge: `inp1`/`inp2` ← 0.
- `start` while not IDLE: ignored; no restart and no queueing.
- `start` held high across DONE: a new run begins from IDLE on the next cycle.
- Pattern counter width: $clog2(`NUM_PATTERNS`+1); no wrap within a run.

## Timing
- Reset values:
  - state IDLE; `inp1`=`inp2`=0;
  - `busy`=0, `done`=0, `pass`=0;
  - `signature`=0; LFSR=8'h01; count=0.
- `busy`=1 in DRIVE, SETTLE and SAMPLE. `done`=1 only in DONE. All outputs are registered.
- `start` sampled high at edge k gives `busy`=1 from k+1, and `done`=1 during cycle k+1+`NUM_PATTERNS`·(`SETTLE_CYC`+2).
- Each pattern is held stable for `SETTLE_CYC`+1 cycles before its SAMPLE edge.
- `dut_out` is sampled at the rising edge that leaves SAMPLE.
- Reset asserted mid-run: all state returns immediately to the reset values; a partial signature is discarded.

## Configuration
- `SIMPLE_BIST_GOLDEN_EN` defined:
  - compare `signature` against `GOLDEN_SIG` on the SAMPLE→DONE edge;
  - `pass` is registered and held until the next start.
- `SIMPLE_BIST_GOLDEN_EN` undefined: no comparator, `pass` tied 0, `GOLDEN_SIG` unused.

## Structure
- `simple_bist_pkg` holds:
  - the FSM state enum (IDLE, DRIVE, SETTLE, SAMPLE, DONE);
  - LFSR_SEED 8'h01, LFSR_TAPS 8'hB8, MISR_POLY 16'h1021, SIG_W 16.
- Sub-module `simple_bist_misr`: 16-bit MISR with clear and enable inputs, instantiated once. The LFSR and FSM stay in the top.

## Test plan
- Reset then idle, `start`=0 for 10 cycles → `busy`=0, `done`=0, `inp1`=`inp2`=0, `signature`=16'h0000.
- `NUM_PATTERNS`=5, `SETTLE_CYC`=2, `dut_out`=0, single `start` pulse:
  - (`inp1`,`inp2`) sequence is (1,0), (0,1), (0,0), (0,0), (1,0), each held 3 cycles;
  - `done` asserts 21 cycles after the start edge;
  - `signature`=16'h0000.
- `NUM_PATTERNS`=2, `dut_out`=1 → final `signature`=16'h0003. With `SIMPLE_BIST_GOLDEN_EN` and `GOLDEN_SIG`=16'h0003 → `pass`=1; with `GOLDEN_SIG`=16'h0002 → `pass`=0.
- `start` pulsed in mid-run SETTLE → ignored; `done` timing and signature are unchanged.
- `tau2015_rst_n` low for 1 cycle during pattern 3:
  - all outputs return to their reset values immediately;
  - a fresh `start` reproduces the full-run signature of an uninterrupted run.
- `start` held high constantly with `NUM_PATTERNS`=1 → runs repeat back-to-back with one IDLE cycle between them; `done` pulses every `SETTLE_CYC`+4 cycles.
